// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode decoupling FIFO of {pc, instr} pairs with valid/ready on both sides.
// The occupancy count is the only full/empty discriminator; flush empties the queue.
module fetch_decode_queue #(
    parameter int          DEPTH     = 2,
    parameter int          PTR_W     = $clog2(DEPTH),
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fdq_entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    fdq_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 push, pop;

    // Readiness depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_pc    = out_valid ? mem[rd_ptr].pc    : 32'h0;
    assign out_instr = out_valid ? mem[rd_ptr].instr : NOP_INSTR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is not reset; occupancy masks stale entries.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized plus directed bench for fetch_decode_queue against a queue-based FIFO model.
module tb_fetch_decode_queue;

    localparam int          DEPTH = 2;
    localparam int          PTR_W = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [31:0]       in_pc = '0;
    logic [31:0]       in_instr = '0;
    logic              in_ready;
    logic              out_valid;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;
    logic              out_ready = 1'b0;
    logic [PTR_W:0]    count;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] model[$];   // {pc, instr}, front = oldest

    fetch_decode_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] head;
        check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(model.size() != 0));
        check_eq({tag, ".in_ready"},  64'(in_ready),  64'(model.size() != DEPTH));
        check_eq({tag, ".count"},     64'(count),     64'(model.size()));
        if (model.size() != 0) begin
            head = model[0];
            check_eq({tag, ".out_pc"},    64'(out_pc),    64'(head[63:32]));
            check_eq({tag, ".out_instr"}, 64'(out_instr), 64'(head[31:0]));
        end else begin
            check_eq({tag, ".out_pc"},    64'(out_pc),    64'h0);
            check_eq({tag, ".out_instr"}, 64'(out_instr), 64'(NOP));
        end
    endtask

    // Called at a negedge: drive, check pre-edge outputs, let the edge happen, update model.
    task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic rdy, input logic fl);
        logic do_push, do_pop;
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy; flush = fl;
        #1;
        check_outputs(tag);
        do_push = v && (model.size() < DEPTH) && !fl;
        do_pop  = (model.size() > 0) && rdy && !fl;
        @(posedge clk);
        if (fl) model.delete();
        else begin
            if (do_pop)  void'(model.pop_front());
            if (do_push) model.push_back({pc, ins});
        end
        @(negedge clk);
    endtask

    initial begin
        // 1 reset
        #3;
        check_eq("reset.out_valid", 64'(out_valid), 64'h0);
        check_eq("reset.out_instr", 64'(out_instr), 64'h13);
        check_eq("reset.out_pc",    64'(out_pc),    64'h0);
        check_eq("reset.in_ready",  64'(in_ready),  64'h1);
        check_eq("reset.count",     64'(count),     64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 2 stream
        cycle("stream0", 1, 32'h00, 32'hA000_0000, 1, 0);
        check_eq("stream.pc0", 64'(out_pc), 64'h00);
        cycle("stream1", 1, 32'h04, 32'hA000_0004, 1, 0);
        check_eq("stream.pc1", 64'(out_pc), 64'h04);
        cycle("stream2", 1, 32'h08, 32'hA000_0008, 1, 0);
        check_eq("stream.pc2", 64'(out_pc), 64'h08);
        cycle("stream3", 0, 32'h0, 32'h0, 1, 0);

        // 3 backpressure: third pair held by fetch until room
        cycle("bp0", 1, 32'h10, 32'hB000_0010, 0, 0);
        cycle("bp1", 1, 32'h14, 32'hB000_0014, 0, 0);
        #1;
        check_eq("bp.count_full", 64'(count),    64'h2);
        check_eq("bp.in_ready",   64'(in_ready), 64'h0);
        #1;
        cycle("bp2", 1, 32'h18, 32'hB000_0018, 1, 0);   // refused despite the pop
        check_eq("bp.head14", 64'(out_pc), 64'h14);
        cycle("bp3", 1, 32'h18, 32'hB000_0018, 1, 0);
        check_eq("bp.head18", 64'(out_pc), 64'h18);
        cycle("bp4", 0, 32'h0, 32'h0, 1, 0);

        // 4 wrap
        for (int i = 0; i < 7; i++)
            cycle("wrap", 1, 32'h100 + 32'(i*4), $urandom, 1, 0);
        cycle("wrap_drain", 0, 32'h0, 32'h0, 1, 0);

        // 5 flush with simultaneous push and pop
        cycle("fl0", 1, 32'h30, 32'hC000_0030, 0, 0);
        cycle("fl1", 1, 32'h34, 32'hC000_0034, 0, 0);
        cycle("fl2", 1, 32'h20, 32'hC000_0020, 1, 1);
        check_eq("flush.count", 64'(count),     64'h0);
        check_eq("flush.valid", 64'(out_valid), 64'h0);
        cycle("fl3", 1, 32'h40, 32'hC000_0040, 0, 0);
        check_eq("flush.head40", 64'(out_pc), 64'h40);

        // 6 async reset mid-stream with count=1
        #2 rst = 1'b0;
        #1;
        check_eq("areset.out_valid", 64'(out_valid), 64'h0);
        check_eq("areset.count",     64'(count),     64'h0);
        in_valid = 1'b0; out_ready = 1'b0;
        model.delete();
        @(negedge clk);
        rst = 1'b1;
        cycle("areset_post", 0, 32'h0, 32'h0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            cycle("rand", ($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC, $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
